// File: rtl/cla_sub_pipe.sv
// Pipelined subtractor D = A - B - bin, one 4-bit carry-look-ahead group per stage.
// Inter-group borrow is registered between stages and the pipe advances globally on adv.
module cla_sub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N = WIDTH / 4;

    // Stage registers; stage k holds result bits [4k+3:0] plus the operands still to be consumed.
    logic [WIDTH-1:0] res_q  [N];
    logic [WIDTH-1:0] a_q    [N];
    logic [WIDTH-1:0] b_q    [N];
    logic             brw_q  [N];
    logic             amsb_q [N];
    logic             bmsb_q [N];
    logic             vld_q  [N];

    logic [WIDTH-1:0] res_d  [N];
    logic [WIDTH-1:0] a_d    [N];
    logic [WIDTH-1:0] b_d    [N];
    logic             brw_d  [N];
    logic             amsb_d [N];
    logic             bmsb_d [N];
    logic             vld_d  [N];

    logic             adv;
    int               prev;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_res;
    logic             src_brw;
    logic [4:0]       grp;

    // Returns {carry_out, sum} of x + ~y + cin using look-ahead carries.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic cin);
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        logic       co;
        p    = x ^ ~y;
        g    = x & ~y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {co, p ^ c};
    endfunction

    assign adv      = ~vld_q[N-1] | out_ready;
    assign in_ready = adv;

    always_comb begin
        prev    = 0;
        src_a   = '0;
        src_b   = '0;
        src_res = '0;
        src_brw = 1'b0;
        grp     = '0;
        for (int k = 0; k < N; k++) begin
            prev = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                src_a     = a;
                src_b     = b;
                src_res   = '0;
                src_brw   = bin;
                amsb_d[k] = a[WIDTH-1];
                bmsb_d[k] = b[WIDTH-1];
                vld_d[k]  = in_valid & adv;
            end else begin
                src_a     = a_q[prev];
                src_b     = b_q[prev];
                src_res   = res_q[prev];
                src_brw   = brw_q[prev];
                amsb_d[k] = amsb_q[prev];
                bmsb_d[k] = bmsb_q[prev];
                vld_d[k]  = vld_q[prev];
            end
            grp      = cla4(4'(src_a >> (4 * k)), 4'(src_b >> (4 * k)), ~src_brw);
            res_d[k] = src_res | (WIDTH'(grp[3:0]) << (4 * k));
            brw_d[k] = ~grp[4];
            a_d[k]   = src_a;
            b_d[k]   = src_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                res_q[k]  <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                brw_q[k]  <= 1'b0;
                amsb_q[k] <= 1'b0;
                bmsb_q[k] <= 1'b0;
                vld_q[k]  <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < N; k++) begin
                res_q[k]  <= res_d[k];
                a_q[k]    <= a_d[k];
                b_q[k]    <= b_d[k];
                brw_q[k]  <= brw_d[k];
                amsb_q[k] <= amsb_d[k];
                bmsb_q[k] <= bmsb_d[k];
                vld_q[k]  <= vld_d[k];
            end
        end
    end

    assign out_valid = vld_q[N-1];
    assign diff      = res_q[N-1];
    assign bout      = brw_q[N-1];
    assign ovf       = (amsb_q[N-1] != bmsb_q[N-1]) & (res_q[N-1][WIDTH-1] != amsb_q[N-1]);

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Directed bench for cla_sub_pipe (WIDTH=16): arithmetic corners, latency, backpressure and
// asynchronous reset of in-flight operations.
module tb_cla_sub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_sub_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation with out_ready=1; checks result, latency and one-cycle pulse.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vbin, input logic [15:0] ed, input logic eb,
                          input logic eo);
        int cyc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        bin       = vbin;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        a        = 16'hdead;
        b        = 16'hbeef;
        bin      = 1'b1;
        cyc      = 1;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 4);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
        check({tag, "_ovf"}, ovf, eo);
        tick();
        check({tag, "_pulse"}, out_valid, 0);
    endtask

    logic [15:0] ta [8];
    logic [15:0] tb_b [8];
    logic        tbin [8];
    logic [15:0] ed [8];
    logic        eb [8];
    logic        eo [8];
    logic [39:0] rdy_pat;

    initial begin
        int          i;
        int          j;
        int          cyc;
        logic        in_x;
        logic        out_x;
        logic        hold;
        logic [15:0] hdiff;
        logic        hb;
        logic        ho;

        ta   = '{16'h0003, 16'h0010, 16'hABCD, 16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h4321};
        tb_b = '{16'h0001, 16'h0020, 16'h1234, 16'hABCD, 16'h7FFF, 16'h8000, 16'h0000, 16'h4321};
        tbin = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        ed   = '{16'h0002, 16'hFFF0, 16'h9999, 16'h6666, 16'h0001, 16'hFFFF, 16'hFFFE, 16'h0000};
        eb   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        eo   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rdy_pat = 40'b1011_0010_1110_0101_1001_1100_0111_0100_1101_0011;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;

        // Reset state, observed before any clock edge.
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 16'h0000);
        check("rst_bout", bout, 0);
        check("rst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid_rel", out_valid, 0);

        run_op("basic",    16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("wrap",     16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("bin_only", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("ffff_bin", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("ripple",   16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        run_op("ovf_neg",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op("ovf_pos",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        run_op("small",    16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Back-to-back stream with a fixed pseudo-random out_ready pattern.
        i    = 0;
        j    = 0;
        cyc  = 0;
        hold = 1'b0;
        hdiff = '0;
        hb   = 1'b0;
        ho   = 1'b0;
        while (j < 8 && cyc < 200) begin
            out_ready = rdy_pat[cyc % 40];
            if (i < 8) begin
                in_valid = 1'b1;
                a        = ta[i];
                b        = tb_b[i];
                bin      = tbin[i];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (hold) begin
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_diff", diff, hdiff);
                check("bp_hold_bout", bout, hb);
                check("bp_hold_ovf", ovf, ho);
            end
            if (out_valid && !out_ready) check("bp_in_ready", in_ready, 0);
            in_x  = in_valid & in_ready;
            out_x = out_valid & out_ready;
            if (out_x) begin
                check("bp_diff", diff, ed[j]);
                check("bp_bout", bout, eb[j]);
                check("bp_ovf", ovf, eo[j]);
                j++;
            end
            hold  = out_valid & ~out_ready;
            hdiff = diff;
            hb    = bout;
            ho    = ovf;
            tick();
            if (in_x) i++;
            cyc++;
        end
        check("bp_count", j, 8);
        check("bp_accepted", i, 8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("bp_no_dup", out_valid, 0);
            tick();
        end

        // Fill the pipe under stall, then reset mid-cycle.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            a        = ta[k] | 16'h1000;
            b        = tb_b[k];
            bin      = 1'b0;
            if (k == 0) begin
                a = 16'h1234;
                b = 16'h0234;
            end
            tick();
        end
        in_valid = 1'b0;
        check("mf_full_valid", out_valid, 1);
        check("mf_full_diff", diff, 16'h1000);
        check("mf_full_in_ready", in_ready, 0);
        #1;
        rst = 1'b1;
        #1;
        check("mf_async_valid", out_valid, 0);
        check("mf_async_diff", diff, 16'h0000);
        check("mf_async_bout", bout, 0);
        tick();
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("mf_no_stale", out_valid, 0);
        end
        run_op("mf_next", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
